rca_seq_ctrl: RTL and testbench
===============================

Name: rca_seq_ctrl

Overview:
Multi-cycle sequencer for a wide add/subtract built on one narrow DW-bit ripple-carry slice. It accepts an NW*DW-bit operand pair via a valid/ready handshake and feeds the slice one digit per clock, least-significant digit first. It registers the inter-digit carry and assembles the result. It sits between a requesting engine and the shared narrow adder, trading latency for area.

Parameters:
DW, 4, slice (digit) width in bits; the adder datapath width.
NW, 4, number of digits per operand; total operand width W = NW*DW (default 16).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request; high only in IDLE.
req_a  input  W  operand A.
req_b  input  W  operand B.
req_cin  input  1  carry-in for add; ignored when req_sub=1.
req_sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
res_sum  output  W  result, modulo 2^W.
res_cout  output  1  final carry out. For subtract: 1 = no borrow (A>=B unsigned).
res_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync-deassert-safe): state=IDLE, req_ready=1, res_valid=0, res_sum=0, res_cout=0, res_ovf=0, busy=0, digit counter=0, carry reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, req_valid&req_ready at edge E0:
  - capture A into a shift reg.
  - capture B (or ~B if req_sub) into a shift reg.
  - carry reg <= req_sub ? 1 : req_cin.
  - counter <= 0; go to RUN.
- RUN, each edge:
  - slice adds the low DW bits of the A and B shift regs plus the carry reg.
  - the slice sum shifts into the top of the result reg (result reg shifts right by DW).
  - carry reg <= slice carry out; A and B shift right by DW; counter++.
  - On the edge where counter==NW-1: go to DONE; latch res_cout = slice carry out; latch res_ovf = carry into the slice MSB XOR slice carry out.
- Latency: exactly NW RUN edges. res_valid goes high in the cycle after edge E_NW (default NW=4: 4 clocks after acceptance). No combinational path from req_* to res_*.
- DONE: res_valid=1. res_sum/res_cout/res_ovf are held stable while res_valid&!res_ready (backpressure, any duration).
  - On res_valid&res_ready: go to IDLE, res_valid<=0. Result outputs keep their last value.
- req_ready=0 in RUN and DONE. req_valid there is ignored and must not disturb the operation. No pipelining: one operation in flight.
- Back-to-back: a request may be accepted in the first IDLE cycle after the DONE handshake. Minimum issue interval is NW+2 cycles.
- Carry chain:
  - Slice 0 uses the captured carry-in.
  - Slice k uses the carry out of slice k-1 from the previous cycle.
  - No carry lost between digits. Wrap-around is modulo 2^W.
- Reset mid-operation (RUN or DONE): immediate abort to the reset state. No partial result is presented and res_valid stays 0.
- Operand changes on req_a/req_b after acceptance have no effect.

Test Plan:
- Add 0x000F+0x0001, cin=0 -> res_sum=0x0010, cout=0, ovf=0. res_valid rises exactly 4 clocks after the accept edge (checks the digit-0 to digit-1 carry).
- Add 0xFFFF+0x0001, cin=0 -> res_sum=0x0000, cout=1, ovf=0. Then 0xFFFF+0xFFFF, cin=1 -> 0xFFFF, cout=1. Then 0x7FFF+0x0001 -> 0x8000, ovf=1, cout=0.
- Subtract 0x0005-0x0007 (req_sub=1, req_cin=1 ignored) -> 0xFFFE, cout=0. Subtract 0x1234-0x0234 -> 0x1000, cout=1. Subtract 0x8000-0x0001 -> 0x7FFF, ovf=1.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> outputs stable, req_ready=0. A new req_valid with different operands during RUN/DONE is ignored; the result matches the first request.
- Back-to-back: two requests with req_valid held high and res_ready=1 -> second accepted in the cycle after the first result handshake; both results correct.
- Reset: assert rst_n=0 for 1 cycle at RUN digit 2 -> all outputs at reset values, req_ready=1. A fresh 0x1111+0x2222 then gives 0x3333, cout=0.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle wide add/subtract sequencer that drives one DW-bit ripple-carry slice,
// least-significant digit first, with a registered inter-digit carry.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// RUN   | one digit per clock through the slice, NW clocks total
// DONE  | result presented; held until res_ready
module rca_seq_ctrl #(
    parameter int DW = 4,
    parameter int NW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DW*NW-1:0]     req_a,
    input  logic [DW*NW-1:0]     req_b,
    input  logic                 req_cin,
    input  logic                 req_sub,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DW*NW-1:0]     res_sum,
    output logic                 res_cout,
    output logic                 res_ovf,
    output logic                 busy
);

    localparam int W  = DW * NW;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-DW-1:0] acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [DW:0]     slice_full;
    logic [DW-1:0]   slice_s;
    logic            slice_co;
    logic            slice_msb_cin;

    // The shared narrow adder: low digit of each operand plus the registered carry.
    assign slice_full    = {1'b0, a_q[DW-1:0]} + {1'b0, b_q[DW-1:0]} + {{DW{1'b0}}, carry_q};
    assign slice_s       = slice_full[DW-1:0];
    assign slice_co      = slice_full[DW];
    assign slice_msb_cin = a_q[DW-1] ^ b_q[DW-1] ^ slice_s[DW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_sub ? ~req_b : req_b;
                    carry_d = req_sub ? 1'b1 : req_cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = {slice_s, acc_q[W-DW-1:DW]};
                a_d     = a_q >> DW;
                b_d     = b_q >> DW;
                carry_d = slice_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Result outputs only move here, so they never show a partial sum.
                    sum_d   = {slice_s, acc_q};
                    cout_d  = slice_co;
                    ovf_d   = slice_msb_cin ^ slice_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl: hand-computed vectors for add, subtract,
// backpressure, back-to-back issue and mid-operation reset.
module tb_rca_seq_ctrl;

    localparam int DW = 4;
    localparam int NW = 4;
    localparam int W  = DW * NW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic         req_sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_ovf;
    logic         busy;

    int vecs = 0;
    int errs = 0;

    rca_seq_ctrl #(.DW(DW), .NW(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request (inputs driven just after an edge), consume the accept edge,
    // then scramble the request inputs to show they are no longer observed.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input string tag);
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_sub   = sub;
        req_valid = 1'b1;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        req_cin   = ~cin;
        req_sub   = ~sub;
    endtask

    // Exactly NW clocks from accept to res_valid.
    task automatic wait_done(input string tag);
        for (int i = 1; i < NW; i++) begin
            chk({tag, ".busy_run"}, 32'(busy), 32'd1);
            tick();
            chk({tag, ".early_valid"}, 32'(res_valid), 32'd0);
        end
        tick();
        chk({tag, ".valid"}, 32'(res_valid), 32'd1);
        chk({tag, ".ready_done"}, 32'(req_ready), 32'd0);
    endtask

    task automatic check_res(input logic [W-1:0] s, input logic c, input logic o,
                             input string tag);
        chk({tag, ".sum"}, 32'(res_sum), 32'(s));
        chk({tag, ".cout"}, 32'(res_cout), 32'(c));
        chk({tag, ".ovf"}, 32'(res_ovf), 32'(o));
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(res_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
        chk({tag, ".busy_drop"}, 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] s, input logic c, input logic o,
                          input string tag);
        start_op(a, b, cin, sub, tag);
        wait_done(tag);
        check_res(s, c, o, tag);
        handshake(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        req_sub   = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.valid", 32'(res_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        check_res(16'h0000, 1'b0, 1'b0, "rst");
        rst_n = 1'b1;
        tick();

        // Adds
        run_op(16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, "add_0f_01");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff_01");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "add_ffff_ffff_c");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_7fff_01");

        // Subtracts (req_cin is ignored)
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_5_7");
        run_op(16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, "sub_1234_0234");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000_1");
        run_op(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_3_3");

        // Backpressure, with a competing request held during RUN/DONE
        start_op(16'h00FF, 16'h0101, 1'b0, 1'b0, "bp");
        req_valid = 1'b1;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        req_cin   = 1'b1;
        req_sub   = 1'b0;
        wait_done("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp.hold_valid", 32'(res_valid), 32'd1);
            chk("bp.hold_ready", 32'(req_ready), 32'd0);
            check_res(16'h0200, 1'b0, 1'b0, "bp.hold");
            tick();
        end
        req_valid = 1'b0;
        check_res(16'h0200, 1'b0, 1'b0, "bp.final");
        handshake("bp");
        check_res(16'h0200, 1'b0, 1'b0, "bp.after_hs");

        // Back-to-back with req_valid and res_ready held high
        res_ready = 1'b1;
        req_a     = 16'h0102;
        req_b     = 16'h0304;
        req_cin   = 1'b0;
        req_sub   = 1'b0;
        req_valid = 1'b1;
        tick();
        req_a = 16'h1000;
        req_b = 16'h2345;
        for (int i = 1; i < NW; i++) begin
            tick();
            chk("b2b1.early_valid", 32'(res_valid), 32'd0);
        end
        tick();
        chk("b2b1.valid", 32'(res_valid), 32'd1);
        check_res(16'h0406, 1'b0, 1'b0, "b2b1");
        tick();
        chk("b2b.idle_valid", 32'(res_valid), 32'd0);
        chk("b2b.idle_ready", 32'(req_ready), 32'd1);
        tick();
        chk("b2b2.accepted", 32'(busy), 32'd1);
        chk("b2b2.ready_low", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        for (int i = 1; i < NW; i++) begin
            tick();
            chk("b2b2.early_valid", 32'(res_valid), 32'd0);
        end
        tick();
        chk("b2b2.valid", 32'(res_valid), 32'd1);
        check_res(16'h3345, 1'b0, 1'b0, "b2b2");
        tick();
        res_ready = 1'b0;
        chk("b2b2.valid_drop", 32'(res_valid), 32'd0);
        chk("b2b2.ready_back", 32'(req_ready), 32'd1);

        // Reset at RUN digit 2
        start_op(16'hABCD, 16'h1234, 1'b0, 1'b0, "rst_mid");
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid.ready", 32'(req_ready), 32'd1);
        chk("rst_mid.valid", 32'(res_valid), 32'd0);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        check_res(16'h0000, 1'b0, 1'b0, "rst_mid");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NW + 2; i++) begin
            tick();
            chk("rst_mid.no_valid", 32'(res_valid), 32'd0);
        end
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
